program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream stage of the accumulator processor: receives program/data words as a framed stream and drives the processor's `wr`, `address`, `port_sel` and port data pins to fill memory bank A/B/C/D.
- Holds the processor halted (`wr`=1) from reset until a frame passes its checksum, then releases it to run (`wr`=0).
- Replaces hand-sequenced testbench loading with a synthesizable bootloader.

Parameters:
- ADDR_WIDTH, 6, processor memory address width (64 words per bank).
- DATA_WIDTH, 11, word width; opcode in [10:6], operand in [5:0].
- HOLD_CYCLES, 3, cycles each word is held on the pins. Minimum 2, because the processor registers `data_in` before writing.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: stream word valid.
- `in_ready` output 1: loader can accept a word.
- `in_data` input DATA_WIDTH: stream word.
- `wr` output 1: processor write enable; 1 = load/halt, 0 = run.
- `address` output ADDR_WIDTH: processor memory address.
- `port_sel` output 4: processor port select; only IN codes are driven: A=0, B=2, C=4, D=6.
- `port_data` output DATA_WIDTH: word driven onto the selected port (system top muxes it onto portA..D).
- `load_done` output 1: sticky, set when a frame passes its checksum.
- `load_err` output 1: sticky, set on bad header or checksum mismatch.

Behaviour:
- Reset is asynchronous and active-high, immediate. Reset values:
  - `wr`=1
  - `address`=0
  - `port_sel`=0
  - `port_data`=0
  - `load_done`=0
  - `load_err`=0
  - state=IDLE
  - internal counters and checksum = 0
- `in_ready` is combinational from state: 1 in IDLE, ADDR, DATA, CSUM, RUN; 0 in WRITE and while reset is asserted.
- A word is accepted on a rising edge with `in_valid` & `in_ready`.
- Frame format:
  - Header: [10:9] bank, [8:6] reserved, must be 0; [5:0] = N-1, so N = 1..64.
  - Start-address word: [5:0].
  - N payload words.
  - Checksum word = XOR of all N payload words.
- State transitions:
  - IDLE, header accepted:
    - Reserved bits nonzero: `load_err`<=1, stay IDLE.
    - Otherwise: latch bank, set `port_sel`<=2*bank, set `wr`<=1, clear `load_done` and `load_err`, go to ADDR.
  - ADDR, word accepted: `address`<=[5:0], word count=0, checksum=0, go to DATA.
  - DATA, word accepted: `port_data`<=word, checksum^=word, hold counter=0, go to WRITE.
  - WRITE: stay exactly HOLD_CYCLES cycles with `address`, `port_data`, `port_sel` stable and `wr`=1. On exit, `address`<=`address`+1 (wraps mod 64, 63->0) and count+1. Go to CSUM if count reaches N, else DATA.
  - CSUM, word accepted:
    - Equal to checksum: `wr`<=0 on that edge, `load_done`<=1, go to RUN.
    - Otherwise: `load_err`<=1, `wr` stays 1, go to IDLE.
  - RUN:
    - `port_sel` and `port_data` hold their last values.
    - A valid header re-enters the load flow exactly as from IDLE, with `wr`<=1 on the accepting edge.
    - Non-header words are not distinguishable, so any accepted word is treated as a header.
- Latency per payload word is 1 accept cycle + HOLD_CYCLES. The first word reaches the pins one cycle after header + address.
- Reset mid-frame:
  - Everything returns to reset values.
  - Words already written stay in processor memory.
  - `load_done` stays 0 until a complete valid frame arrives.
- Bubbles: `in_valid` low in any accepting state simply waits, with no timeout.
- `port_sel` never takes an OUT code (odd value).

Test Plan:
- Bank A, 3-word frame:
  - Stimulus: header 0x002, addr 0x000, words 0x0A2, 0x163, 0x064, checksum 0x1A5.
  - Required: `address` 0,1,2 each held 3 cycles with `port_sel`=0 and `wr`=1; then `wr`=0 and `load_done`=1 on the checksum edge.
  - After release, processor memory holds LOAD 34, ADD 35, STORE 36.
- Checksum mismatch:
  - Stimulus: same frame with checksum 0x1A4.
  - Required: `load_err`=1, `wr` stays 1, state IDLE; a correct resend then sets `load_done`=1 and clears `load_err`.
- Bank D, wrap-around:
  - Stimulus: header 0x601 (bank 3, N=2), addr 0x03F, words 0x005, 0x007, checksum 0x002.
  - Required: `port_sel`=6, writes at `address` 63 then 0, `load_done`=1.
- Bad header:
  - Stimulus: header 0x040 (reserved bit 6 set).
  - Required: `load_err`=1, `in_ready` stays 1, no address/addr-word consumption; the next word is treated as a header.
- Backpressure and reset mid-operation:
  - Stimulus: `in_valid` held high continuously during a 4-word frame, then `reset` pulsed during the 2nd WRITE.
  - Required: `in_ready`=0 for exactly 3 cycles per word; at reset all outputs immediately return to 1/0/0/0/0/0 (`wr`/`address`/`port_sel`/`port_data`/`load_done`/`load_err`) and `in_ready`=0 while reset is high.
- Re-load from RUN:
  - Stimulus: after a successful load, send header 0x200 (bank B, N=1), addr 5, word 0x3FF, checksum 0x3FF.
  - Required: `wr` rises on the header edge, `port_sel`=2, `address`=5 held 3 cycles, then `wr`=0 and `load_done`=1.

Source files
------------

// File: rtl/program_loader.sv
// Framed-stream bootloader for the accumulator processor: writes payload words into
// bank A/B/C/D through the processor's load pins, then releases it to run.
module program_loader #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [3:0]            port_sel,
  output logic [DATA_WIDTH-1:0] port_data,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_RUN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [ADDR_WIDTH-1:0] count;
  logic [HOLD_W-1:0]     hold;
  logic [DATA_WIDTH-1:0] csum;
  logic                  accept;
  logic                  hdr_bad;
  logic [1:0]            hdr_bank;

  // Only the write-hold phase (and reset) stalls the stream.
  assign in_ready = !reset && (state != S_WRITE);
  assign accept   = in_valid && in_ready;
  assign hdr_bank = in_data[DATA_WIDTH-1 -: 2];
  assign hdr_bad  = |in_data[DATA_WIDTH-3:ADDR_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wr        <= 1'b1;
      address   <= '0;
      port_sel  <= '0;
      port_data <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      last_idx  <= '0;
      count     <= '0;
      hold      <= '0;
      csum      <= '0;
    end else begin
      case (state)
        // A running processor cannot tell data from headers, so RUN parses headers too.
        S_IDLE, S_RUN: begin
          if (accept) begin
            if (hdr_bad) begin
              load_err <= 1'b1;
            end else begin
              port_sel  <= {1'b0, hdr_bank, 1'b0};
              wr        <= 1'b1;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              last_idx  <= in_data[ADDR_WIDTH-1:0];
              state     <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (accept) begin
            address <= in_data[ADDR_WIDTH-1:0];
            count   <= '0;
            csum    <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            port_data <= in_data;
            csum      <= csum ^ in_data;
            hold      <= '0;
            state     <= S_WRITE;
          end
        end
        // Pins stay stable long enough for the processor to register and write the word.
        S_WRITE: begin
          if (hold == HOLD_W'(HOLD_CYCLES - 1)) begin
            address <= address + ADDR_WIDTH'(1);
            count   <= count + ADDR_WIDTH'(1);
            state   <= (count == last_idx) ? S_CSUM : S_DATA;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              wr        <= 1'b0;
              load_done <= 1'b1;
              state     <= S_RUN;
            end else begin
              load_err <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames against a frame-level model of the loader and a
// behavioural stand-in for the processor's memory banks.
module tb_program_loader;

  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = 11;
  localparam int unsigned HOLD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          wr;
  logic [AW-1:0] address;
  logic [3:0]    port_sel;
  logic [DW-1:0] port_data;
  logic          load_done;
  logic          load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] cap_mem   [4][64];
  logic [DW-1:0] ref_mem   [4][64];
  bit            ref_valid [4][64];
  logic [DW-1:0] q[$];

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr(wr), .address(address), .port_sel(port_sel), .port_data(port_data),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Processor stand-in: writes whatever the loader holds on the pins while it stalls the stream.
  always @(posedge clk)
    if (!reset && wr && !in_ready) cap_mem[port_sel[2:1]][address] <= port_data;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one word (starting at a negedge) and return at the negedge after it is accepted.
  task automatic send(input logic [DW-1:0] w, input bit bubbles);
    int guard = 0;
    if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [1:0] bank, input logic [AW-1:0] start,
                            input logic [DW-1:0] words[$], input bit good, input bit keep,
                            input bit bubbles, input int abort_at);
    logic [DW-1:0] cs;
    logic [AW-1:0] a;
    int n;
    n  = words.size();
    cs = '0;
    foreach (words[i]) cs = cs ^ words[i];
    if (!good) cs = cs ^ 11'h001;

    send({bank, 3'b000, AW'(n - 1)}, bubbles);
    check("hdr_wr", wr, 1);
    check("hdr_port_sel", port_sel, 2 * bank);
    check("hdr_done_clr", load_done, 0);
    check("hdr_err_clr", load_err, 0);

    send({5'b00000, start}, bubbles);
    check("start_addr", address, start);

    for (int i = 0; i < n; i++) begin
      a = start + AW'(i);
      send(words[i], bubbles);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_wr", wr, 1);
        check("rst_address", address, 0);
        check("rst_port_sel", port_sel, 0);
        check("rst_port_data", port_data, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_ready", in_ready, 0);
        @(negedge clk);
        check("rst_ready_hold", in_ready, 0);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("post_rst_done", load_done, 0);
        check("post_rst_ready", in_ready, 1);
        return;
      end
      if (keep) begin
        in_valid = 1'b1;
        in_data  = (i + 1 < n) ? words[i+1] : cs;
      end
      for (int h = 0; h < int'(HOLD); h++) begin
        check("hold_ready", in_ready, 0);
        check("hold_address", address, a);
        check("hold_data", port_data, words[i]);
        check("hold_port_sel", port_sel, 2 * bank);
        check("hold_wr", wr, 1);
        @(negedge clk);
      end
      check("post_hold_ready", in_ready, 1);
      ref_mem[bank][a]   = words[i];
      ref_valid[bank][a] = 1'b1;
    end

    send(cs, bubbles);
    if (good) begin
      check("ok_wr", wr, 0);
      check("ok_done", load_done, 1);
      check("ok_err", load_err, 0);
    end else begin
      check("bad_wr", wr, 1);
      check("bad_err", load_err, 1);
      check("bad_done", load_done, 0);
      check("bad_ready", in_ready, 1);
    end
  endtask

  initial begin
    logic [1:0]    rb;
    logic [AW-1:0] rs;
    int            rn;
    bit            rk;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("reset_wr", wr, 1);
    check("reset_address", address, 0);
    check("reset_port_sel", port_sel, 0);
    check("reset_port_data", port_data, 0);
    check("reset_done", load_done, 0);
    check("reset_err", load_err, 0);
    check("reset_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 1);

    // Bank A program: LOAD 34, ADD 35, STORE 36
    q = {11'h0A2, 11'h163, 11'h064};
    load_frame(2'd0, 6'd0, q, 1'b1, 1'b0, 1'b0, -1);
    check("memA0", cap_mem[0][0], 11'h0A2);
    check("memA1", cap_mem[0][1], 11'h163);
    check("memA2", cap_mem[0][2], 11'h064);

    // Same frame with a corrupted checksum, then a bad header, then a clean resend
    load_frame(2'd0, 6'd0, q, 1'b0, 1'b0, 1'b0, -1);
    send(11'h040, 1'b0);
    check("badhdr_err", load_err, 1);
    check("badhdr_ready", in_ready, 1);
    check("badhdr_wr", wr, 1);
    load_frame(2'd0, 6'd0, q, 1'b1, 1'b0, 1'b0, -1);

    // Bank D, address wrap 63 -> 0
    q = {11'h005, 11'h007};
    load_frame(2'd3, 6'd63, q, 1'b1, 1'b0, 1'b0, -1);
    check("memD63", cap_mem[3][63], 11'h005);
    check("memD0", cap_mem[3][0], 11'h007);

    // Continuous valid through a 4-word frame, reset during the second write
    q = {};
    repeat (4) q.push_back(DW'($urandom_range(0, 2047)));
    load_frame(2'd1, 6'd10, q, 1'b1, 1'b1, 1'b0, 1);

    // Load, then re-load bank B from RUN
    q = {11'h111, 11'h222};
    load_frame(2'd2, 6'd20, q, 1'b1, 1'b0, 1'b1, -1);
    q = {11'h3FF};
    load_frame(2'd1, 6'd5, q, 1'b1, 1'b0, 1'b0, -1);

    // Randomized frames, including one full 64-word bank
    for (int f = 0; f < 10; f++) begin
      rb = 2'($urandom_range(0, 3));
      rs = AW'($urandom_range(0, 63));
      rn = (f == 5) ? 64 : int'($urandom_range(1, 6));
      rk = 1'($urandom_range(0, 1));
      q = {};
      repeat (rn) q.push_back(DW'($urandom_range(0, 2047)));
      load_frame(rb, rs, q, ($urandom_range(0, 3) != 0), rk, !rk, -1);
    end

    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++)
        if (ref_valid[b][a]) check($sformatf("mem_b%0d_a%0d", b, a), cap_mem[b][a], ref_mem[b][a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
